led_band_multi_controller: RTL and testbench
============================================

// Module: led_band_multi_controller
// PURPOSE
//  Drives NB_BANDS LED-band drivers in parallel from one synchronizer stream. Each band
//  has its own double-buffered colour bank and a fixed angular offset (bands equally
//  spaced on the plate). Replaces the single-band controller: adds deferred frame swap
//  at angle boundaries and an internal FC load sequencer shifting FC data to all bands.
// PARAMETERS
//  NB_BANDS            4    number of LED bands / SOUT lanes (power of 2, >=1)
//  NB_LED_ROWS         32   leds per face per band (power of 2)
//  NB_ANGLES           128  angular positions (power of 2, multiple of NB_BANDS)
//  PCB_ANGLE           0    angle offset common to all bands
//  COLOR_DATA_WIDTH    8    bits per colour in memory
//  NB_ADDED_LSB_BITS   1    zero LSBs appended to each GS word
//  COLOR_W_DATA_WIDTH  128  colour write word width (multiple of COLOR_DATA_WIDTH)
//  FC_WIDTH            48   FC register length shifted to drivers
// PORTS
//  clk            in   1    system clock
//  rst            in   1    asynchronous reset, active-low
//  SCLK           in   1    driver shift clock (clk-synchronous level)
//  LAT            in   1    driver latch (clk-synchronous level)
//  angle          in   clog2(NB_ANGLES)  current angular position
//  led_row        in   clog2(NB_LED_ROWS) row being shifted
//  color          in   2    0=R 1=G 2=B (3 = unused, outputs 0)
//  bit_sel        in   clog2(CDW+NB_ADDED_LSB_BITS) GS bit index
//  color_w_addr   in   clog2(NB_BANDS*BANK_BYTES/BPW) word address (BANK_BYTES=3*ROWS*ANGLES, BPW=CW_DW/CDW)
//  color_w_data   in   COLOR_W_DATA_WIDTH  packed colour bytes, byte 0 = [CDW-1:0]
//  color_w_enable in   1    colour write strobe
//  fc_w_data      in   FC_WIDTH  FC value
//  fc_w_enable    in   1    FC write/commit strobe
//  new_frame      in   1    HPS frame-complete pulse
//  hps_override   in   1    route hps_SOUT to all lanes
//  hps_SOUT       in   NB_BANDS  per-lane HPS data
//  SOUT           out  NB_BANDS  per-lane driver serial data
//  swap_pending   out  1    frame swap requested, not yet applied
//  fc_busy        out  1    FC sequencer not in GS state
// BEHAVIOUR
//  Reset (async assert, sync release): SOUT=0, buffer_choice=0, swap_pending=0, fc_busy=0,
//   FC shadow/shift regs=0, FSM=GS, pipeline regs=0.
//  Memory: per band 2 buffers x BANK_BYTES bytes. Write byte address A=color_w_addr*BPW+i;
//   band=A/BANK_BYTES, offset=A%BANK_BYTES, buffer=buffer_choice (value before any same-cycle swap).
//  Read: per band b, angle_b=(angle+PCB_ANGLE+b*NB_ANGLES/NB_BANDS) mod NB_ANGLES
//   (wrap by truncation); offset=(angle_b*3+color)*NB_LED_ROWS+led_row; buffer=~buffer_choice.
//  GS lane: word {data,NB_ADDED_LSB_BITS'0}; SOUT_GS[b]=word[bit_sel]; bit_sel>=width -> 0;
//   color==3 -> 0. Latency: 2 clk from inputs to SOUT (address reg + sync RAM read).
//  Frame swap: new_frame sets swap_pending. Swap (buffer_choice toggles, swap_pending clears)
//   on first clk where angle differs from its previous-cycle value. new_frame coincident with
//   angle change swaps that cycle. new_frame while pending: no extra effect (one swap).
//  Edges: SCLK/LAT registered once; rise/fall detected against registered copy.
//  FC FSM: GS -> ARMED on fc_w_enable (fc_w_data -> shadow). ARMED -> SHIFT on next LAT fall:
//   shadow -> shift reg, bit count=FC_WIDTH. SHIFT: SOUT_FC=shift MSB; on each SCLK fall
//   shift left, count--; count 0 -> WAIT. WAIT -> GS on next LAT fall. fc_busy=(FSM!=GS).
//  fc_w_enable in SHIFT/WAIT: shadow updated, re-arm after return (GS->ARMED next cycle);
//   in-flight shift unaffected.
//  Output mux per lane: hps_override -> hps_SOUT[b]; else FSM in SHIFT/WAIT -> SOUT_FC
//   (same on all lanes); else SOUT_GS[b]. SOUT registered.
//  Reads disabled (RAM data held) while FSM in SHIFT/WAIT.
// TESTING
//  1. Write byte 0x5A at band1 buf0 offset for angle_b=0,R,row0; new_frame; step angle
//     -> swap, band1 SOUT emits 0101_1010_0 for bit_sel 8..0, 2 clk after each bit_sel.
//  2. NB_BANDS=4, NB_ANGLES=128: angle=100 -> band3 reads angle_b=(100+96)%128=68.
//  3. new_frame x3 with angle static -> swap_pending=1, buffer_choice unchanged; angle change
//     -> exactly one toggle, swap_pending=0.
//  4. fc_w_data=48'hA5..., fc_w_enable, LAT pulse, 48 SCLK -> all lanes shift value MSB
//     first; fc_busy drops after next LAT fall; SOUT returns to GS data.
//  5. hps_override=1, hps_SOUT=4'b1010 during FC SHIFT -> SOUT=1010; shift count still runs.
//  6. Assert rst mid-SHIFT -> SOUT=0, fc_busy=0, buffer_choice=0 immediately.

Source files
------------

// File: rtl/led_band_multi_controller.sv
// Multi-band LED controller: per-band double-buffered colour banks, deferred frame swap, FC shift sequencer.
// GS path: 2 clk from inputs to SOUT. No backpressure: writes are always accepted, SCLK/LAT are paced externally.
module led_band_multi_controller #(
  parameter int NB_BANDS           = 4,
  parameter int NB_LED_ROWS        = 32,
  parameter int NB_ANGLES          = 128,
  parameter int PCB_ANGLE          = 0,
  parameter int COLOR_DATA_WIDTH   = 8,
  parameter int NB_ADDED_LSB_BITS  = 1,
  parameter int COLOR_W_DATA_WIDTH = 128,
  parameter int FC_WIDTH           = 48
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        SCLK,
  input  logic                                        LAT,
  input  logic [$clog2(NB_ANGLES)-1:0]                angle,
  input  logic [$clog2(NB_LED_ROWS)-1:0]              led_row,
  input  logic [1:0]                                  color,
  input  logic [$clog2(COLOR_DATA_WIDTH+NB_ADDED_LSB_BITS)-1:0] bit_sel,
  input  logic [$clog2(NB_BANDS*3*NB_LED_ROWS*NB_ANGLES*COLOR_DATA_WIDTH/COLOR_W_DATA_WIDTH)-1:0] color_w_addr,
  input  logic [COLOR_W_DATA_WIDTH-1:0]               color_w_data,
  input  logic                                        color_w_enable,
  input  logic [FC_WIDTH-1:0]                         fc_w_data,
  input  logic                                        fc_w_enable,
  input  logic                                        new_frame,
  input  logic                                        hps_override,
  input  logic [NB_BANDS-1:0]                         hps_SOUT,
  output logic [NB_BANDS-1:0]                         SOUT,
  output logic                                        swap_pending,
  output logic                                        fc_busy
);

  localparam int ANGLE_W    = $clog2(NB_ANGLES);
  localparam int GS_W       = COLOR_DATA_WIDTH + NB_ADDED_LSB_BITS;
  localparam int BPW        = COLOR_W_DATA_WIDTH / COLOR_DATA_WIDTH;
  localparam int BANK_BYTES = 3 * NB_LED_ROWS * NB_ANGLES;
  localparam int BA_W       = $clog2(NB_BANDS * BANK_BYTES) + 1;
  localparam int OFF_W      = $clog2(BANK_BYTES);
  localparam int BAND_W     = (NB_BANDS > 1) ? $clog2(NB_BANDS) : 1;
  localparam int CNT_W      = $clog2(FC_WIDTH + 1);
  localparam int BAND_STEP  = NB_ANGLES / NB_BANDS;

  localparam logic [1:0] ST_GS    = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  logic                        buffer_choice;
  logic [ANGLE_W-1:0]          angle_q;
  logic                        do_swap;

  logic                        sclk_q, lat_q;
  logic                        sclk_fall, lat_fall;
  logic [1:0]                  fc_state;
  logic                        fc_rearm;
  logic                        fc_drive;
  logic [FC_WIDTH-1:0]         fc_shadow, fc_shift;
  logic [CNT_W-1:0]            fc_cnt;

  logic [COLOR_DATA_WIDTH-1:0] mem [NB_BANDS][2][BANK_BYTES];

  logic [BA_W-1:0]             wr_base, wr_band0, wr_off0, wr_sum;
  logic [BA_W-1:0]             wr_band [BPW];
  logic [OFF_W-1:0]            wr_off  [BPW];

  logic [1:0]                  rd_color;
  logic [ANGLE_W-1:0]          rd_angle [NB_BANDS];
  logic [OFF_W-1:0]            rd_off_d [NB_BANDS];
  logic [OFF_W-1:0]            rd_off_q [NB_BANDS];
  logic                        rd_buf_q;
  logic [$bits(bit_sel)-1:0]   bit_sel_q;
  logic                        blank_q;
  logic [GS_W-1:0]             gs_word [NB_BANDS];
  logic [NB_BANDS-1:0]         gs_bit;

  assign fc_drive  = (fc_state == ST_SHIFT) || (fc_state == ST_WAIT);
  assign fc_busy   = (fc_state != ST_GS);
  assign sclk_fall = sclk_q && !SCLK;
  assign lat_fall  = lat_q && !LAT;
  assign do_swap   = (angle != angle_q) && (swap_pending || new_frame);

  // One divider per word; later bytes of the word can only spill into the next band (BPW <= BANK_BYTES).
  always_comb begin
    wr_base  = BA_W'(color_w_addr) * BA_W'(BPW);
    wr_band0 = wr_base / BA_W'(BANK_BYTES);
    wr_off0  = wr_base % BA_W'(BANK_BYTES);
    wr_sum   = '0;
    for (int i = 0; i < BPW; i++) begin
      wr_sum = wr_off0 + BA_W'(i);
      if (wr_sum >= BA_W'(BANK_BYTES)) begin
        wr_band[i] = wr_band0 + BA_W'(1);
        wr_off[i]  = OFF_W'(wr_sum - BA_W'(BANK_BYTES));
      end else begin
        wr_band[i] = wr_band0;
        wr_off[i]  = OFF_W'(wr_sum);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (color_w_enable) begin
      for (int i = 0; i < BPW; i++) begin
        if (wr_band[i] < BA_W'(NB_BANDS))
          mem[wr_band[i][BAND_W-1:0]][buffer_choice][wr_off[i]] <=
            color_w_data[i*COLOR_DATA_WIDTH +: COLOR_DATA_WIDTH];
      end
    end
  end

  // Colour 3 is blanked at the output; mapping it to R keeps the read index inside the bank.
  always_comb begin
    rd_color = (color == 2'd3) ? 2'd0 : color;
    for (int b = 0; b < NB_BANDS; b++) begin
      rd_angle[b] = ANGLE_W'(int'(angle) + PCB_ANGLE + b * BAND_STEP);
      rd_off_d[b] = OFF_W'((int'(rd_angle[b]) * 3 + int'(rd_color)) * NB_LED_ROWS + int'(led_row));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < NB_BANDS; b++) rd_off_q[b] <= '0;
      rd_buf_q  <= 1'b0;
      bit_sel_q <= '0;
      blank_q   <= 1'b0;
    end else if (!fc_drive) begin
      for (int b = 0; b < NB_BANDS; b++) rd_off_q[b] <= rd_off_d[b];
      rd_buf_q  <= ~buffer_choice;
      bit_sel_q <= bit_sel;
      blank_q   <= (color == 2'd3) || (int'(bit_sel) >= GS_W);
    end
  end

  always_comb begin
    for (int b = 0; b < NB_BANDS; b++) begin
      gs_word[b] = GS_W'(mem[b][rd_buf_q][rd_off_q[b]]) << NB_ADDED_LSB_BITS;
      gs_bit[b]  = blank_q ? 1'b0 : gs_word[b][bit_sel_q];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              SOUT <= '0;
    else if (hps_override) SOUT <= hps_SOUT;
    else if (fc_drive)     SOUT <= {NB_BANDS{fc_shift[FC_WIDTH-1]}};
    else                   SOUT <= gs_bit;
  end

  // A pending swap waits for the next angle step so a frame never changes mid-position.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      angle_q       <= '0;
      buffer_choice <= 1'b0;
      swap_pending  <= 1'b0;
    end else begin
      angle_q <= angle;
      if (do_swap) begin
        buffer_choice <= ~buffer_choice;
        swap_pending  <= 1'b0;
      end else if (new_frame) begin
        swap_pending  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_q    <= 1'b0;
      lat_q     <= 1'b0;
      fc_state  <= ST_GS;
      fc_rearm  <= 1'b0;
      fc_shadow <= '0;
      fc_shift  <= '0;
      fc_cnt    <= '0;
    end else begin
      sclk_q <= SCLK;
      lat_q  <= LAT;
      if (fc_w_enable) fc_shadow <= fc_w_data;
      if (fc_w_enable && fc_drive) fc_rearm <= 1'b1;
      case (fc_state)
        ST_GS: begin
          if (fc_w_enable || fc_rearm) begin
            fc_state <= ST_ARMED;
            fc_rearm <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (lat_fall) begin
            fc_state <= ST_SHIFT;
            fc_shift <= fc_shadow;
            fc_cnt   <= CNT_W'(FC_WIDTH);
          end
        end
        ST_SHIFT: begin
          if (sclk_fall) begin
            fc_shift <= {fc_shift[FC_WIDTH-2:0], 1'b0};
            fc_cnt   <= fc_cnt - CNT_W'(1);
            if (fc_cnt <= CNT_W'(1)) fc_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat_fall) fc_state <= ST_GS;
        end
        default: fc_state <= ST_GS;
      endcase
    end
  end

endmodule

// File: tb/tb_led_band_multi_controller.sv
// Directed bench for led_band_multi_controller: GS readout, band offsets, frame swap, FC shifting,
// HPS override and reset during a shift, each checked against hand-computed values.
module tb_led_band_multi_controller;

  logic         clk = 1'b0;
  logic         rst;
  logic         SCLK, LAT;
  logic [6:0]   angle;
  logic [4:0]   led_row;
  logic [1:0]   color;
  logic [3:0]   bit_sel;
  logic [11:0]  color_w_addr;
  logic [127:0] color_w_data;
  logic         color_w_enable;
  logic [47:0]  fc_w_data;
  logic         fc_w_enable;
  logic         new_frame;
  logic         hps_override;
  logic [3:0]   hps_SOUT;
  logic [3:0]   SOUT;
  logic         swap_pending;
  logic         fc_busy;

  int runs  = 0;
  int fails = 0;

  localparam logic [47:0] V1 = 48'hA5C3_0F96_1E78;
  localparam logic [47:0] V2 = 48'hC0FF_EE12_3457;
  localparam logic [47:0] V3 = 48'h8123_4567_89AB;

  led_band_multi_controller dut (
    .clk(clk), .rst(rst), .SCLK(SCLK), .LAT(LAT), .angle(angle), .led_row(led_row),
    .color(color), .bit_sel(bit_sel), .color_w_addr(color_w_addr), .color_w_data(color_w_data),
    .color_w_enable(color_w_enable), .fc_w_data(fc_w_data), .fc_w_enable(fc_w_enable),
    .new_frame(new_frame), .hps_override(hps_override), .hps_SOUT(hps_SOUT), .SOUT(SOUT),
    .swap_pending(swap_pending), .fc_busy(fc_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_word(input logic [11:0] addr, input logic [127:0] data);
    color_w_addr = addr; color_w_data = data; color_w_enable = 1'b1;
    tick();
    color_w_enable = 1'b0;
  endtask

  task automatic pulse_lat();
    LAT = 1'b1; tick();
    LAT = 1'b0; tick();
  endtask

  task automatic pulse_sclk();
    SCLK = 1'b1; tick();
    SCLK = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(2);
    runs++; if (SOUT !== 4'b0000) begin fails++; $display("FAIL reset_sout: got %b want 0000", SOUT); end
    runs++; if (swap_pending !== 1'b0) begin fails++; $display("FAIL reset_swap_pending: got %b want 0", swap_pending); end
    runs++; if (fc_busy !== 1'b0) begin fails++; $display("FAIL reset_fc_busy: got %b want 0", fc_busy); end
    runs++; if (dut.buffer_choice !== 1'b0) begin fails++; $display("FAIL reset_buffer_choice: got %b want 0", dut.buffer_choice); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_gs_read();
    logic [8:0] exp9;
    // band1 angle_b 0 R rows 0/1 -> bytes 0,1 of word 768; band0 angle 100 R row0 -> word 600; band3 angle_b 68 -> word 2712
    write_word(12'd768,  128'h815A);
    write_word(12'd600,  128'h3C);
    write_word(12'd2712, 128'hC3);
    angle = 7'd95; tick();
    new_frame = 1'b1; tick(); new_frame = 1'b0;
    runs++; if (swap_pending !== 1'b1) begin fails++; $display("FAIL gs_pending: got %b want 1", swap_pending); end
    runs++; if (dut.buffer_choice !== 1'b0) begin fails++; $display("FAIL gs_no_early_swap: got %b want 0", dut.buffer_choice); end
    angle = 7'd96; tick();
    runs++; if (dut.buffer_choice !== 1'b1) begin fails++; $display("FAIL gs_swap: got %b want 1", dut.buffer_choice); end
    runs++; if (swap_pending !== 1'b0) begin fails++; $display("FAIL gs_pending_clr: got %b want 0", swap_pending); end
    color = 2'd0; led_row = 5'd0;
    exp9 = 9'b0_1011_0100;
    for (int i = 8; i >= 0; i--) begin
      bit_sel = 4'(i);
      tick(2);
      runs++; if (SOUT[1] !== exp9[i]) begin fails++; $display("FAIL gs_bit%0d: got %b want %b", i, SOUT[1], exp9[i]); end
    end
    led_row = 5'd1; bit_sel = 4'd8; tick(2);
    runs++; if (SOUT[1] !== 1'b1) begin fails++; $display("FAIL gs_row1_b8: got %b want 1", SOUT[1]); end
    bit_sel = 4'd1; tick(2);
    runs++; if (SOUT[1] !== 1'b1) begin fails++; $display("FAIL gs_row1_b1: got %b want 1", SOUT[1]); end
    led_row = 5'd0; bit_sel = 4'd9; tick(2);
    runs++; if (SOUT[1] !== 1'b0) begin fails++; $display("FAIL gs_bitsel_oob: got %b want 0", SOUT[1]); end
    bit_sel = 4'd4; color = 2'd3; tick(2);
    runs++; if (SOUT[1] !== 1'b0) begin fails++; $display("FAIL gs_color3: got %b want 0", SOUT[1]); end
    color = 2'd0;
  endtask

  task automatic test_band_offset();
    angle = 7'd100; led_row = 5'd0; color = 2'd0;
    bit_sel = 4'd8; tick(2);
    runs++; if (SOUT[3] !== 1'b1) begin fails++; $display("FAIL band3_b8: got %b want 1", SOUT[3]); end
    runs++; if (SOUT[0] !== 1'b0) begin fails++; $display("FAIL band0_b8: got %b want 0", SOUT[0]); end
    bit_sel = 4'd3; tick(2);
    runs++; if (SOUT[3] !== 1'b0) begin fails++; $display("FAIL band3_b3: got %b want 0", SOUT[3]); end
    runs++; if (SOUT[0] !== 1'b1) begin fails++; $display("FAIL band0_b3: got %b want 1", SOUT[0]); end
  endtask

  task automatic test_swap();
    repeat (3) begin
      new_frame = 1'b1; tick();
      new_frame = 1'b0; tick();
    end
    runs++; if (swap_pending !== 1'b1) begin fails++; $display("FAIL swap_pending3: got %b want 1", swap_pending); end
    runs++; if (dut.buffer_choice !== 1'b1) begin fails++; $display("FAIL swap_static: got %b want 1", dut.buffer_choice); end
    angle = 7'd101; tick();
    runs++; if (dut.buffer_choice !== 1'b0) begin fails++; $display("FAIL swap_toggle: got %b want 0", dut.buffer_choice); end
    runs++; if (swap_pending !== 1'b0) begin fails++; $display("FAIL swap_clear: got %b want 0", swap_pending); end
    tick();
    runs++; if (dut.buffer_choice !== 1'b0) begin fails++; $display("FAIL swap_once: got %b want 0", dut.buffer_choice); end
    new_frame = 1'b1; angle = 7'd96; tick(); new_frame = 1'b0;
    runs++; if (dut.buffer_choice !== 1'b1) begin fails++; $display("FAIL swap_coincident: got %b want 1", dut.buffer_choice); end
    runs++; if (swap_pending !== 1'b0) begin fails++; $display("FAIL swap_coincident_pend: got %b want 0", swap_pending); end
  endtask

  task automatic test_fc_shift();
    led_row = 5'd0; color = 2'd0; bit_sel = 4'd7; tick(2);
    fc_w_data = V1; fc_w_enable = 1'b1; tick(); fc_w_enable = 1'b0;
    runs++; if (fc_busy !== 1'b1) begin fails++; $display("FAIL fc_armed_busy: got %b want 1", fc_busy); end
    pulse_lat();
    tick();
    for (int i = 47; i >= 0; i--) begin
      runs++; if (SOUT !== {4{V1[i]}}) begin fails++; $display("FAIL fc_bit%0d: got %b want %b", i, SOUT, {4{V1[i]}}); end
      pulse_sclk();
      tick();
    end
    runs++; if (fc_busy !== 1'b1) begin fails++; $display("FAIL fc_wait_busy: got %b want 1", fc_busy); end
    runs++; if (SOUT !== 4'b0000) begin fails++; $display("FAIL fc_wait_sout: got %b want 0000", SOUT); end
    pulse_lat();
    runs++; if (fc_busy !== 1'b0) begin fails++; $display("FAIL fc_done_busy: got %b want 0", fc_busy); end
    tick(3);
    runs++; if (SOUT[1] !== 1'b1) begin fails++; $display("FAIL fc_gs_return: got %b want 1", SOUT[1]); end
  endtask

  task automatic test_hps_override();
    fc_w_data = V2; fc_w_enable = 1'b1; tick(); fc_w_enable = 1'b0;
    pulse_lat();
    tick();
    hps_override = 1'b1; hps_SOUT = 4'b1010; tick();
    runs++; if (SOUT !== 4'b1010) begin fails++; $display("FAIL hps_sout: got %b want 1010", SOUT); end
    fc_w_data = V3; fc_w_enable = 1'b1; tick(); fc_w_enable = 1'b0;
    repeat (47) pulse_sclk();
    runs++; if (SOUT !== 4'b1010) begin fails++; $display("FAIL hps_hold: got %b want 1010", SOUT); end
    hps_override = 1'b0; tick(2);
    runs++; if (SOUT !== {4{V2[0]}}) begin fails++; $display("FAIL hps_count_ran: got %b want %b", SOUT, {4{V2[0]}}); end
    runs++; if (fc_busy !== 1'b1) begin fails++; $display("FAIL hps_busy: got %b want 1", fc_busy); end
    pulse_sclk(); tick();
    runs++; if (SOUT !== 4'b0000) begin fails++; $display("FAIL hps_wait_sout: got %b want 0000", SOUT); end
    pulse_lat();
    runs++; if (fc_busy !== 1'b0) begin fails++; $display("FAIL rearm_gs: got %b want 0", fc_busy); end
    tick();
    runs++; if (fc_busy !== 1'b1) begin fails++; $display("FAIL rearm_armed: got %b want 1", fc_busy); end
  endtask

  task automatic test_reset_mid_shift();
    pulse_lat();
    tick();
    runs++; if (SOUT !== {4{V3[47]}}) begin fails++; $display("FAIL rearm_msb: got %b want %b", SOUT, {4{V3[47]}}); end
    #2 rst = 1'b0;
    #1;
    runs++; if (SOUT !== 4'b0000) begin fails++; $display("FAIL rst_sout: got %b want 0000", SOUT); end
    runs++; if (fc_busy !== 1'b0) begin fails++; $display("FAIL rst_fc_busy: got %b want 0", fc_busy); end
    runs++; if (dut.buffer_choice !== 1'b0) begin fails++; $display("FAIL rst_buffer_choice: got %b want 0", dut.buffer_choice); end
    tick();
    rst = 1'b1;
    tick(2);
    runs++; if (fc_busy !== 1'b0) begin fails++; $display("FAIL rst_release_busy: got %b want 0", fc_busy); end
    runs++; if (swap_pending !== 1'b0) begin fails++; $display("FAIL rst_release_pending: got %b want 0", swap_pending); end
  endtask

  initial begin
    rst = 1'b0; SCLK = 1'b0; LAT = 1'b0; angle = '0; led_row = '0; color = '0; bit_sel = '0;
    color_w_addr = '0; color_w_data = '0; color_w_enable = 1'b0; fc_w_data = '0; fc_w_enable = 1'b0;
    new_frame = 1'b0; hps_override = 1'b0; hps_SOUT = '0;
    test_reset();
    test_gs_read();
    test_band_offset();
    test_swap();
    test_fc_shift();
    test_hps_override();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", runs, fails);
    $finish;
  end

endmodule
